arg_pop_scheduler: RTL
======================

ARG_POP_SCHEDULER -- requirements
Module: arg_pop_scheduler

Interface
REQ-001 Parameter WIDTH_OUT, 64, decoder output width in bits.
REQ-002 Parameter LOG2_WIDTH_OUT, log2(WIDTH_OUT), width of a pop length.
REQ-003 Parameter NUM_REQ, 4, number of requesters (2..8).
REQ-004 clk  input  1  single clock; all logic on the rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 req_valid  input  NUM_REQ  per-requester pop request.
REQ-007 req_len  input  NUM_REQ*LOG2_WIDTH_OUT  per-requester bit count; slice i = requester i.
REQ-008 req_ack  output  NUM_REQ  one-hot, one-cycle acceptance of the pending request.
REQ-009 resp_valid  output  1  response strobe.
REQ-010 resp_id  output  log2(NUM_REQ)  index of the served requester.
REQ-011 resp_data  output  WIDTH_OUT  popped bits, LSB-aligned, zero-extended.
REQ-012 dec_ready  input  1  decoder holds at least WIDTH_OUT valid bits.
REQ-013 dec_q  input  WIDTH_OUT  decoder window; bit WIDTH_OUT-1 is the oldest bit.
REQ-014 dec_pop  output  LOG2_WIDTH_OUT  bits consumed this cycle; 0 = no pop.

Function
REQ-015 FSM states: IDLE, ISSUE, SETTLE.
REQ-016 IDLE: when any req_valid is high and dec_ready is high, select a winner and go to ISSUE; otherwise stay.
REQ-017 Arbitration: round-robin; search starts at the index after the last winner; after reset the search starts at 0.
REQ-018 ISSUE lasts exactly one cycle, with the following outputs: req_ack[winner]=1, dec_pop=req_len[winner], resp_valid=1, resp_id=winner, resp_data=dec_q>>(WIDTH_OUT-len).
REQ-019 The response is combinational from the dec_q value in the ISSUE cycle, so latency from winner selection to response is 1 cycle.
REQ-020 ISSUE always goes to SETTLE; SETTLE lasts one cycle so the decoder size and window update; then go to IDLE.
REQ-021 Throughput is at most one pop per 3 cycles per scheduler.
REQ-022 The winner index and length are registered on entry to ISSUE; changes to req_valid or req_len during ISSUE or SETTLE are ignored.
REQ-023 Zero-length request: ISSUE still acks, with dec_pop=0, resp_data=0 and resp_valid=1; no decoder bits are consumed.
REQ-024 dec_ready low in IDLE: no grant; requests wait without limit.
REQ-025 dec_ready falling during ISSUE: the pop still completes.
REQ-026 A requester whose req_valid drops before selection loses nothing; the round-robin pointer advances only on ISSUE.
REQ-027 Outside ISSUE, all of the following are 0: req_ack, dec_pop, resp_valid, resp_id, resp_data.

Reset
REQ-028 rst asserted at any time forces IDLE within the same cycle: all outputs 0 and round-robin pointer 0.
REQ-029 A pop interrupted by rst is not retried; the requester must re-request.

Configuration
REQ-030 Macro ARG_POP_SCHEDULER_STATS_EN, when defined, adds output grant_count (32 bits): the count of ISSUE cycles with nonzero dec_pop, reset to 0, saturating at all-ones.
REQ-031 Macro ARG_POP_SCHEDULER_STATS_EN, when undefined, removes the grant_count port and its counter; all other behaviour is identical.

Structure
REQ-032 The FSM state encoding and the log2 helper live in the shared package/header used by the decoder blocks.
REQ-033 The round-robin selection is a sub-module rr_arbiter, with inputs req, pointer and advance, and outputs a one-hot grant and an index.

Verification
REQ-034 Reset check: rst pulsed mid-ISSUE -> all outputs 0 immediately; the next grant goes to requester 0.
REQ-035 Single pop: req_valid=0001, req_len[0]=5, dec_ready=1, dec_q=64'hF800_..._0 -> one cycle later req_ack=0001, dec_pop=5, resp_data=0x1F, resp_id=0.
REQ-036 Fairness: all four requesters held valid -> grants go 0,1,2,3,0, each 3 cycles apart.
REQ-037 Stall: dec_ready=0 for 10 cycles with req_valid=0010 -> no ack; the ack arrives 1 cycle after dec_ready rises.
REQ-038 Zero length: req_len=0 -> ack, resp_valid=1, dec_pop=0, resp_data=0; with STATS_EN defined, grant_count is unchanged.
REQ-039 Input glitch: req_len changed from 7 to 3 during ISSUE -> dec_pop stays 7.

Source files
------------

// File: rtl/arg_pop_scheduler_pkg.sv
// rtl/arg_pop_scheduler_pkg.sv - shared FSM state encoding and log2 helper for the decoder blocks
package arg_pop_scheduler_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ISSUE  = 2'd1,
    ST_SETTLE = 2'd2
  } state_e;

  // Ceiling log2, usable in parameter defaults.
  function automatic int log2c(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/arg_pop_scheduler_rr_arbiter.sv
// rtl/arg_pop_scheduler_rr_arbiter.sv - round-robin winner search starting at a given pointer
module rr_arbiter
  import arg_pop_scheduler_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = log2c(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    pointer,
  input  logic               advance,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    index
);

  logic            found;
  int              cand;
  logic [ID_W-1:0] cidx;

  // Scan from pointer upward, wrapping; grant is empty unless advance is set.
  always_comb begin
    grant = '0;
    index = '0;
    found = 1'b0;
    cand  = 0;
    cidx  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = int'(pointer) + k;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      cidx = ID_W'(cand);
      if (advance && !found && req[cidx]) begin
        found       = 1'b1;
        grant[cidx] = 1'b1;
        index       = cidx;
      end
    end
  end

endmodule

// File: rtl/arg_pop_scheduler.sv
// rtl/arg_pop_scheduler.sv - round-robin bit-pop scheduler in front of a decoder window
// Optional grant_count statistics output enabled by ARG_POP_SCHEDULER_STATS_EN.
module arg_pop_scheduler
  import arg_pop_scheduler_pkg::*;
#(
  parameter int WIDTH_OUT      = 64,
  parameter int LOG2_WIDTH_OUT = log2c(WIDTH_OUT),
  parameter int NUM_REQ        = 4
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [NUM_REQ-1:0]                req_valid,
  input  logic [NUM_REQ*LOG2_WIDTH_OUT-1:0] req_len,
  output logic [NUM_REQ-1:0]                req_ack,
  output logic                              resp_valid,
  output logic [log2c(NUM_REQ)-1:0]         resp_id,
  output logic [WIDTH_OUT-1:0]              resp_data,
  input  logic                              dec_ready,
  input  logic [WIDTH_OUT-1:0]              dec_q,
  output logic [LOG2_WIDTH_OUT-1:0]         dec_pop
`ifdef ARG_POP_SCHEDULER_STATS_EN
  ,
  output logic [31:0]                       grant_count
`endif
);

  localparam int ID_W = log2c(NUM_REQ);
  localparam int SH_W = LOG2_WIDTH_OUT + 1;

  state_e                    state_q;
  logic [ID_W-1:0]           ptr_q, ptr_d;
  logic [NUM_REQ-1:0]        ack_q;
  logic [LOG2_WIDTH_OUT-1:0] pop_q;
  logic                      rv_q;
  logic [ID_W-1:0]           id_q;

  logic                      start;
  logic [NUM_REQ-1:0]        arb_grant;
  logic [ID_W-1:0]           arb_idx;
  logic [LOG2_WIDTH_OUT-1:0] win_len;
  logic [SH_W-1:0]           shamt;

  assign start = (state_q == ST_IDLE) && dec_ready && (|req_valid);

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_rr_arbiter (
    .req     (req_valid),
    .pointer (ptr_q),
    .advance (start),
    .grant   (arb_grant),
    .index   (arb_idx)
  );

  always_comb begin
    win_len = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (arb_idx == ID_W'(i)) win_len = req_len[i*LOG2_WIDTH_OUT +: LOG2_WIDTH_OUT];
    end
  end

  assign ptr_d = (int'(arb_idx) == NUM_REQ - 1) ? '0 : arb_idx + ID_W'(1);

  // Outputs are registered on entry to ISSUE and self-clear on the next edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      ack_q   <= '0;
      pop_q   <= '0;
      rv_q    <= 1'b0;
      id_q    <= '0;
    end else begin
      ack_q <= '0;
      pop_q <= '0;
      rv_q  <= 1'b0;
      id_q  <= '0;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_q <= ST_ISSUE;
            ptr_q   <= ptr_d;
            ack_q   <= arb_grant;
            pop_q   <= win_len;
            rv_q    <= 1'b1;
            id_q    <= arb_idx;
          end
        end
        ST_ISSUE: state_q <= ST_SETTLE;
        default:  state_q <= ST_IDLE;
      endcase
    end
  end

  // Oldest bits sit at the top of the window; a zero length must yield zero.
  assign shamt = SH_W'(WIDTH_OUT) - SH_W'(pop_q);

  always_comb begin
    resp_data = '0;
    if (state_q == ST_ISSUE && pop_q != '0) resp_data = dec_q >> shamt;
  end

  assign req_ack    = ack_q;
  assign dec_pop    = pop_q;
  assign resp_valid = rv_q;
  assign resp_id    = id_q;

`ifdef ARG_POP_SCHEDULER_STATS_EN
  logic [31:0] cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (state_q == ST_ISSUE && pop_q != '0 && cnt_q != '1) begin
      cnt_q <= cnt_q + 32'd1;
    end
  end

  assign grant_count = cnt_q;
`endif

endmodule
